cam_switch_ctrl: RTL and testbench
==================================

CAM_SWITCH_CTRL -- requirements
Module: cam_switch_ctrl

Interface
REQ-001 Parameter FRAME_TIMEOUT, default 2_000_000: number of clk cycles without a vsync rising edge after which a camera is declared lost.
REQ-002 Parameter AUTO_FRAMES, default 30: number of frames shown per camera in alternate mode.
REQ-003 Parameter CNT_W, default 22: width of the watchdog counters; it SHALL satisfy 2^CNT_W > FRAME_TIMEOUT.
REQ-004 clk  input  1  single clock for the whole block; all inputs are already synchronous to clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cam1_vsync, cam2_vsync  input  1 each  camera frame syncs; a rising edge marks frame start.
REQ-007 cam1_inited, cam2_inited  input  1 each  camera configuration-done flags.
REQ-008 mode  input  1  0 = manual, 1 = alternate.
REQ-009 sel_req  input  1  requested source in manual mode; 0 = cam1, 1 = cam2.
REQ-010 sel  output  1  current display source; the mux select for the display pipeline.
REQ-011 sel_valid  output  1  high when sel points at a live camera and its output may be displayed.
REQ-012 switch_pulse  output  1  one-cycle pulse on the cycle sel changes.
REQ-013 frame_start  output  1  one-cycle pulse on each vsync rising edge of the selected camera while in RUN or PEND.
REQ-014 cam_alive  output  2  bit0 = cam1 alive, bit1 = cam2 alive.

Function
REQ-015 Edge detect: the block SHALL register each vsync; edge = vsync AND NOT vsync_q.
REQ-016 Watchdog per camera:
- the counter SHALL clear to 0 on an edge;
- otherwise it SHALL increment, saturating at FRAME_TIMEOUT;
- alive = inited AND (counter < FRAME_TIMEOUT).
REQ-017 The next-state logic SHALL use the alive value computed in the same cycle, so an edge makes its camera alive immediately.
REQ-018 The FSM SHALL have states WAIT, RUN and PEND; target denotes the camera the FSM is heading to.
REQ-019 WAIT: sel_valid = 0.
- On the first cycle any camera is alive, the FSM SHALL move to RUN.
- sel = 0 if cam1 is alive, else 1 (cam1 wins ties).
- switch_pulse SHALL fire if sel changed.
REQ-020 Target in RUN:
- manual mode: target = sel_req;
- alternate mode: target = NOT sel once the frame counter reaches AUTO_FRAMES, else target = sel.
REQ-021 Frame counter:
- counts edges of the selected camera while in RUN;
- clears on every sel change and on every mode change;
- saturates at AUTO_FRAMES.
REQ-022 RUN, in priority order:
- (a) selected camera not alive and other camera alive -> PEND with target = other;
- (b) neither camera alive -> WAIT, sel_valid = 0 in the same cycle as the transition;
- (c) target != sel and target alive -> PEND;
- (d) otherwise stay in RUN.
- A requested target that is not alive SHALL be ignored; the FSM stays in RUN.
REQ-023 PEND: sel is unchanged and sel_valid remains as in RUN, except sel_valid = 0 while the current camera is not alive.
- On a target edge: sel <= target, switch_pulse = 1, frame_start = 1, -> RUN.
- Target lost -> RUN if the current camera is alive, else WAIT.
- In manual mode, sel_req returning to sel SHALL abort PEND -> RUN with no switch.
- A target edge and an abort in the same cycle: abort wins.
REQ-024 Switch timing: a switch SHALL occur only on the new camera's vsync rising edge, never mid-frame; latency from request to sel change = cycles to the next target edge + 1 clk.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst is high, and asynchronously upon its assertion:
- state = WAIT;
- sel = 0, sel_valid = 0, switch_pulse = 0, frame_start = 0;
- vsync_q = 0;
- watchdog counters = FRAME_TIMEOUT, so cam_alive = 2'b00;
- frame counter = 0.
REQ-027 On rst deassertion, a camera SHALL be declared alive only after its first observed edge; a reset asserted mid-PEND SHALL cancel the pending switch.

Verification (FRAME_TIMEOUT = 1000, AUTO_FRAMES = 3, vsync period 500 clk)
REQ-028 Both inited, cam2 edge first at t = 100, cam1 edge at t = 300:
- t = 101: sel = 1, sel_valid = 1;
- no switch at t = 300;
- cam_alive = 2'b11 after t = 300.
REQ-029 Manual: sel = 0, sel_req goes to 1 at t0:
- sel stays 0 until the next cam2 edge at tc;
- sel = 1 and switch_pulse = 1 at tc + 1, exactly one pulse.
REQ-030 Alternate with both cameras running:
- sel toggles after every 3rd edge of the selected camera;
- switch_pulse count = 4 after 12 + 4 frames.
REQ-031 cam1 selected, cam1 vsync stops at t = 0:
- cam_alive[0] = 0 at t ≈ 1000 (watchdog expiry);
- switch to cam2 on the next cam2 edge;
- if cam2 also stops, sel_valid = 0 and the FSM is in WAIT.
REQ-032 In PEND, sel_req is toggled back before the target edge -> no switch_pulse and sel is unchanged; separately, sel_req toggled back in the same cycle as the target edge -> no switch.
REQ-033 rst asserted for 3 cycles mid-PEND -> all outputs at reset values within the same cycle as assertion; after release, sel_valid = 0 until the first edge.

Source files
------------

// File: rtl/cam_switch_ctrl.sv
// Dual-camera source selector: per-camera vsync watchdogs plus a WAIT/RUN/PEND
// FSM that moves the display mux only on the incoming camera's frame start.
module cam_switch_ctrl #(
  parameter int FRAME_TIMEOUT = 2_000_000,
  parameter int AUTO_FRAMES   = 30,
  parameter int CNT_W         = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cam1_vsync,
  input  logic       cam2_vsync,
  input  logic       cam1_inited,
  input  logic       cam2_inited,
  input  logic       mode,
  input  logic       sel_req,
  output logic       sel,
  output logic       sel_valid,
  output logic       switch_pulse,
  output logic       frame_start,
  output logic [1:0] cam_alive
);

  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [CNT_W-1:0] FT_C = CNT_W'(FRAME_TIMEOUT);
  localparam logic [FC_W-1:0]  AF_C = FC_W'(AUTO_FRAMES);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_PEND
  } state_t;

  state_t           state;
  logic [1:0]       vsync_in;
  logic [1:0]       vsync_q;
  logic [1:0]       vs_edge;
  logic [1:0]       inited;
  logic [1:0]       alive;
  logic [CNT_W-1:0] wd_q    [2];
  logic [CNT_W-1:0] wd_next [2];
  logic [FC_W-1:0]  fcnt;
  logic             mode_q;
  logic             tgt;
  logic             run_tgt;

  always_comb begin
    vsync_in = {cam2_vsync, cam1_vsync};
    inited   = {cam2_inited, cam1_inited};
    vs_edge  = vsync_in & ~vsync_q;
  end

  // Liveness is taken from the post-update count so an edge revives its camera this cycle.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (vs_edge[i])
        wd_next[i] = '0;
      else if (wd_q[i] >= FT_C)
        wd_next[i] = FT_C;
      else
        wd_next[i] = wd_q[i] + 1'b1;
      alive[i] = inited[i] && (wd_next[i] < FT_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q   <= '0;
      cam_alive <= '0;
      for (int unsigned i = 0; i < 2; i++)
        wd_q[i] <= FT_C;
    end else begin
      vsync_q   <= vsync_in;
      cam_alive <= alive;
      for (int unsigned i = 0; i < 2; i++)
        wd_q[i] <= wd_next[i];
    end
  end

  always_comb begin
    if (mode)
      run_tgt = (fcnt >= AF_C) ? ~sel : sel;
    else
      run_tgt = sel_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_WAIT;
      sel          <= 1'b0;
      sel_valid    <= 1'b0;
      switch_pulse <= 1'b0;
      frame_start  <= 1'b0;
      tgt          <= 1'b0;
      fcnt         <= '0;
      mode_q       <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      frame_start  <= 1'b0;
      mode_q       <= mode;
      case (state)
        ST_WAIT: begin
          sel_valid <= 1'b0;
          if (|alive) begin
            state     <= ST_RUN;
            sel_valid <= 1'b1;
            sel       <= ~alive[0];
            if (sel == alive[0]) begin
              switch_pulse <= 1'b1;
              fcnt         <= '0;
            end
          end
        end
        ST_RUN: begin
          frame_start <= vs_edge[sel];
          if (vs_edge[sel] && (fcnt < AF_C))
            fcnt <= fcnt + 1'b1;
          if (!alive[sel] && alive[~sel]) begin
            state     <= ST_PEND;
            tgt       <= ~sel;
            sel_valid <= 1'b0;
          end else if (!alive[sel]) begin
            state     <= ST_WAIT;
            sel_valid <= 1'b0;
          end else if ((run_tgt != sel) && alive[run_tgt]) begin
            state     <= ST_PEND;
            tgt       <= run_tgt;
            sel_valid <= 1'b1;
          end else begin
            sel_valid <= 1'b1;
          end
        end
        ST_PEND: begin
          frame_start <= vs_edge[sel];
          sel_valid   <= alive[sel];
          // Abort is tested first so it beats a coincident target edge.
          if (!mode && (sel_req == sel)) begin
            state <= ST_RUN;
          end else if (!alive[tgt]) begin
            state <= alive[sel] ? ST_RUN : ST_WAIT;
          end else if (vs_edge[tgt]) begin
            state        <= ST_RUN;
            sel          <= tgt;
            sel_valid    <= 1'b1;
            switch_pulse <= 1'b1;
            frame_start  <= 1'b1;
            fcnt         <= '0;
          end
        end
        default: begin
          state     <= ST_WAIT;
          sel_valid <= 1'b0;
        end
      endcase
      if (mode != mode_q)
        fcnt <= '0;
    end
  end

endmodule

// File: tb/tb_cam_switch_ctrl.sv
// Bench for cam_switch_ctrl: directed camera scenarios followed by random
// traffic, checked per cycle against a behavioural model through a scoreboard.
module tb_cam_switch_ctrl;

  localparam int FT = 1000;
  localparam int AF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cam1_vsync = 1'b0, cam2_vsync = 1'b0;
  logic       cam1_inited = 1'b0, cam2_inited = 1'b0;
  logic       mode = 1'b0, sel_req = 1'b0;
  logic       sel, sel_valid, switch_pulse, frame_start;
  logic [1:0] cam_alive;

  always #5 clk = ~clk;

  cam_switch_ctrl #(
    .FRAME_TIMEOUT(FT),
    .AUTO_FRAMES  (AF),
    .CNT_W        (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cam1_vsync  (cam1_vsync),
    .cam2_vsync  (cam2_vsync),
    .cam1_inited (cam1_inited),
    .cam2_inited (cam2_inited),
    .mode        (mode),
    .sel_req     (sel_req),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .switch_pulse(switch_pulse),
    .frame_start (frame_start),
    .cam_alive   (cam_alive)
  );

  typedef struct packed {
    logic       sel;
    logic       valid;
    logic       sp;
    logic       fs;
    logic [1:0] alive;
  } out_t;

  out_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   cyc = 0;

  // stimulus state
  bit   [1:0] en;
  bit   [1:0] init;
  int         per [2];
  int         ph  [2];
  bit         m_mode, m_req, rst_drv;

  // reference model state: frame age per camera, chosen source, pending target
  bit   [1:0] m_vsq;
  int         age [2];
  bit         m_run, m_sel, m_valid, m_prevmode;
  int         m_pend;
  int         frames;

  function automatic void model_reset();
    m_vsq      = 2'b00;
    age        = '{FT, FT};
    m_run      = 1'b0;
    m_sel      = 1'b0;
    m_valid    = 1'b0;
    m_pend     = -1;
    frames     = 0;
    m_prevmode = 1'b0;
  endfunction

  function automatic out_t model_step(bit [1:0] vs);
    out_t    o;
    bit [1:0] e, al;
    int      want;
    bit      ns;
    o = '0;
    e = vs & ~m_vsq;
    m_vsq = vs;
    for (int i = 0; i < 2; i++) begin
      age[i] = e[i] ? 0 : ((age[i] >= FT) ? FT : age[i] + 1);
      al[i]  = init[i] && (age[i] < FT);
    end
    if (m_pend >= 0) begin
      o.fs    = e[m_sel];
      m_valid = al[m_sel];
      if (!m_mode && (m_req == m_sel)) begin
        m_pend = -1;
      end else if (!al[m_pend]) begin
        m_pend = -1;
        if (!al[m_sel]) m_run = 1'b0;
      end else if (e[m_pend]) begin
        m_sel   = m_pend[0];
        o.sp    = 1'b1;
        o.fs    = 1'b1;
        frames  = 0;
        m_pend  = -1;
        m_valid = 1'b1;
      end
    end else if (m_run) begin
      want = m_mode ? ((frames >= AF) ? int'(!m_sel) : int'(m_sel)) : int'(m_req);
      o.fs = e[m_sel];
      if (e[m_sel] && frames < AF) frames++;
      if (!al[m_sel]) begin
        m_valid = 1'b0;
        if (al[!m_sel]) m_pend = int'(!m_sel);
        else m_run = 1'b0;
      end else begin
        m_valid = 1'b1;
        if ((want != int'(m_sel)) && al[want]) m_pend = want;
      end
    end else begin
      if (al != 2'b00) begin
        ns = !al[0];
        if (ns != m_sel) begin
          o.sp   = 1'b1;
          frames = 0;
        end
        m_sel   = ns;
        m_run   = 1'b1;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (m_mode != m_prevmode) frames = 0;
    m_prevmode = m_mode;
    o.sel   = m_sel;
    o.valid = m_valid;
    o.alive = al;
    return o;
  endfunction

  task automatic step(int n);
    for (int k = 0; k < n; k++) begin
      bit [1:0] vs;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        vs[i] = en[i] && (cyc >= ph[i]) && (((cyc - ph[i]) % per[i]) < 20);
      rst         = rst_drv;
      cam1_vsync  = vs[0];
      cam2_vsync  = vs[1];
      cam1_inited = init[0];
      cam2_inited = init[1];
      mode        = m_mode;
      sel_req     = m_req;
      if (rst_drv) begin
        model_reset();
        expq.push_back(out_t'(0));
      end else begin
        expq.push_back(model_step(vs));
      end
      cyc++;
    end
  endtask

  task automatic run_to(int c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Reset lands mid-cycle; the entry queued for the coming edge becomes the reset value.
  task automatic async_reset();
    #2;
    rst     = 1'b1;
    rst_drv = 1'b1;
    #1;
    check("async_rst", int'({sel, sel_valid, switch_pulse, frame_start, cam_alive}), 0);
    expq.delete();
    expq.push_back(out_t'(0));
    model_reset();
    step(3);
    rst_drv = 1'b0;
  endtask

  initial begin : monitor
    out_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (switch_pulse) pulses++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {sel, sel_valid, switch_pulse, frame_start, cam_alive};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got sel/valid/pulse/fs/alive=%b expected=%b", cyc, g, e);
        end
      end
    end
  end

  initial begin : stim
    int p0, j, rhold;
    model_reset();
    en = 2'b11; init = 2'b11;
    per = '{500, 500};
    ph  = '{300, 100};
    m_mode = 1'b0; m_req = 1'b1; rst_drv = 1'b1;
    step(3);
    rst_drv = 1'b0;
    cyc = 0;

    // cam2 comes up first, cam1 later; no switch when cam1 appears
    run_to(400);
    check("boot_alive", int'(cam_alive), 3);
    check("boot_sel", int'(sel), 1);
    check("boot_valid", int'(sel_valid), 1);
    check("boot_pulses", pulses, 1);

    // manual switch waits for the target edge
    p0 = pulses; m_req = 1'b0;
    run_to(700);
    check("manual_hold", int'(sel), 1);
    run_to(1000);
    check("manual_sel0", int'(sel), 0);
    check("manual_one_pulse", pulses - p0, 1);
    p0 = pulses; m_req = 1'b1;
    run_to(1300);
    check("manual_sel1", int'(sel), 1);
    check("manual_one_pulse2", pulses - p0, 1);

    // abort before the target edge, then abort coinciding with it
    p0 = pulses; m_req = 1'b0;
    run_to(1400);
    m_req = 1'b1;
    run_to(1900);
    check("abort_sel", int'(sel), 1);
    check("abort_no_pulse", pulses - p0, 0);
    m_req = 1'b0;
    run_to(2300);
    m_req = 1'b1;
    run_to(2500);
    check("abort_edge_sel", int'(sel), 1);
    check("abort_edge_no_pulse", pulses - p0, 0);

    // alternate mode: four switches over sixteen frame periods
    p0 = pulses; m_mode = 1'b1;
    run_to(10500);
    check("alt_pulses", pulses - p0, 4);
    check("alt_sel", int'(sel), 1);

    // selected camera stops: watchdog expiry, failover, then total loss
    p0 = pulses; en[1] = 1'b0;
    run_to(11200);
    check("wd_alive", int'(cam_alive), 1);
    run_to(11400);
    check("failover_sel", int'(sel), 0);
    check("failover_pulse", pulses - p0, 1);
    en[0] = 1'b0;
    run_to(13000);
    check("lost_valid", int'(sel_valid), 0);
    check("lost_alive", int'(cam_alive), 0);

    // reset in the middle of a pending switch
    en = 2'b11; m_mode = 1'b0; m_req = 1'b0;
    run_to(13500);
    check("pend_sel", int'(sel), 1);
    async_reset();
    run_to(13560);
    check("post_rst_valid", int'(sel_valid), 0);
    check("post_rst_alive", int'(cam_alive), 0);
    run_to(13700);
    check("post_rst_sel", int'(sel), 1);
    check("post_rst_valid2", int'(sel_valid), 1);

    // random traffic
    per[0] = $urandom_range(700, 300);
    per[1] = $urandom_range(700, 300);
    ph[0]  = cyc + $urandom_range(299, 0);
    ph[1]  = cyc + $urandom_range(299, 0);
    rhold  = 0;
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(399, 0) == 0) m_mode = ~m_mode;
      if ($urandom_range(249, 0) == 0) m_req = ~m_req;
      j = $urandom_range(1, 0);
      if ($urandom_range(2999, 0) == 0) en[j] = ~en[j];
      j = $urandom_range(1, 0);
      if ($urandom_range(4999, 0) == 0) init[j] = ~init[j];
      if (rhold > 0) rhold--;
      else if ($urandom_range(5999, 0) == 0) rhold = 2;
      rst_drv = (rhold > 0);
      step(1);
    end
    rst_drv = 1'b0;
    step(2);
    @(posedge clk);
    #2;
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
